// File: rtl/speaker_i2s_tx.sv
// I2S transmitter for the PMOD audio DAC: square-wave tone at note_div pitch, 3-bit volume,
// one 16-bit sample latched per 512-cycle frame. Optional macro NOTE_RESTART_EN restarts the tone on note change.
module speaker_i2s_tx (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] note_div,
  input  logic [2:0]  volume,
  output logic        audio_mclk,
  output logic        audio_sck,
  output logic        audio_lrck,
  output logic        audio_sdin
);

  localparam int unsigned FCNT_W = 9;
  localparam int unsigned DIV_W  = 22;
  localparam int unsigned SMP_W  = 16;

  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [DIV_W-1:0]  hcnt_q, hcnt_d;
  logic              phase_q, phase_d;
  logic [SMP_W-1:0]  smp_q, smp_d;
  logic              sdin_q, sdin_d;
  logic [SMP_W-1:0]  amp;
  logic [SMP_W-1:0]  sample;
`ifdef NOTE_RESTART_EN
  logic [DIV_W-1:0]  note_q;
`endif

  // Volume to amplitude, clamped at 0x4000 so +/-amp never overflows.
  always_comb begin
    amp = '0;
    case (volume)
      3'd0:                         amp = '0;
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5: amp = SMP_W'(16'h0200 << volume);
      default:                      amp = 16'h4000;
    endcase
  end

  always_comb begin
    sample = '0;
    if (note_div != '0) begin
      sample = phase_q ? amp : SMP_W'(~amp + 16'd1);
    end
  end

  // Tone half-period counter; >= keeps hcnt bounded when note_div shrinks.
  always_comb begin
    hcnt_d  = hcnt_q + 22'd1;
    phase_d = phase_q;
    if (note_div == '0) begin
      hcnt_d  = '0;
      phase_d = 1'b0;
    end
`ifdef NOTE_RESTART_EN
    else if (note_div != note_q) begin
      hcnt_d  = '0;
      phase_d = 1'b0;
    end
`endif
    else if (hcnt_q >= note_div - 22'd1) begin
      hcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  // Sample latched at frame end; sdin pre-computed from next state so it lands with fcnt.
  always_comb begin
    fcnt_d = fcnt_q + 9'd1;
    smp_d  = (fcnt_q == 9'd511) ? sample : smp_q;
    sdin_d = smp_d[4'd15 - fcnt_d[7:4]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q  <= '0;
      hcnt_q  <= '0;
      phase_q <= 1'b0;
      smp_q   <= '0;
      sdin_q  <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      hcnt_q  <= hcnt_d;
      phase_q <= phase_d;
      smp_q   <= smp_d;
      sdin_q  <= sdin_d;
    end
  end

`ifdef NOTE_RESTART_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      note_q <= '0;
    end else begin
      note_q <= note_div;
    end
  end
`endif

  assign audio_mclk = fcnt_q[1];
  assign audio_sck  = fcnt_q[3];
  assign audio_lrck = fcnt_q[8];
  assign audio_sdin = sdin_q;

endmodule

// File: tb/tb_speaker_i2s_tx.sv
// Bench for speaker_i2s_tx: directed tone/volume/silence/note-change/reset frames,
// expected frame words queued by the stimulus and checked bit-exact by a monitor.
module tb_speaker_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [21:0] note_div = 22'd512;
  logic [2:0]  volume = 3'd2;
  logic        audio_mclk, audio_sck, audio_lrck, audio_sdin;

  speaker_i2s_tx dut (
    .clk        (clk),
    .rst        (rst),
    .note_div   (note_div),
    .volume     (volume),
    .audio_mclk (audio_mclk),
    .audio_sck  (audio_sck),
    .audio_lrck (audio_lrck),
    .audio_sdin (audio_sdin)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frames_done = 0;
  int now_t = 0;
  logic [15:0] exp_q[$];

  // Volume per frame k and the word that frame k+1 must carry (phase = k%2 at each latch).
  localparam logic [2:0]  VOL_A [11] = '{3'd2, 3'd2, 3'd7, 3'd7, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd2};
  localparam logic [15:0] EXP_A [11] = '{16'hF800, 16'h0800, 16'hC000, 16'h4000, 16'hFC00, 16'h1000,
                                         16'hE000, 16'h4000, 16'hC000, 16'h0000, 16'hF800};
`ifdef NOTE_RESTART_EN
  localparam logic [15:0] EXP_B [5] = '{16'hF800, 16'hF800, 16'h0800, 16'h0800, 16'h0800};
`else
  localparam logic [15:0] EXP_B [5] = '{16'h0800, 16'h0800, 16'hF800, 16'hF800, 16'hF800};
`endif

  // Reference frame position and sampled reset.
  logic [8:0] tb_f = '0;
  logic       rst_s = 1'b0;
  always @(posedge clk) begin
    rst_s <= rst;
    tb_f  <= rst ? 9'd0 : tb_f + 9'd1;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  task automatic go_to(input int t);
    repeat (t - now_t) @(posedge clk);
    #1;
    now_t = t;
  endtask

  // Monitor: clock outputs every cycle; frame words captured at first and last cycle of each bit.
  initial begin
    logic armed = 1'b0;
    logic have_frame = 1'b0;
    logic [15:0] cur = '0;
    logic [15:0] el = '0, ll = '0, er = '0, lr = '0;
    forever begin
      @(negedge clk);
      if (rst_s) armed = 1'b1;
      if (armed) begin
        chk("mclk", 16'(audio_mclk), 16'(tb_f[1]));
        chk("sck",  16'(audio_sck),  16'(tb_f[3]));
        chk("lrck", 16'(audio_lrck), 16'(tb_f[8]));
      end
      if (rst_s) begin
        chk("reset_sdin", 16'(audio_sdin), 16'h0000);
        have_frame = 1'b0;
      end
      if (!rst && tb_f == 9'd0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_queue actual=empty required=entry");
          have_frame = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          have_frame = 1'b1;
        end
      end
      if (tb_f[3:0] == 4'd0) begin
        if (tb_f[8]) er = {er[14:0], audio_sdin};
        else         el = {el[14:0], audio_sdin};
      end
      if (tb_f[3:0] == 4'd15) begin
        if (tb_f[8]) lr = {lr[14:0], audio_sdin};
        else         ll = {ll[14:0], audio_sdin};
      end
      if (have_frame && !rst && tb_f == 9'd511) begin
        chk($sformatf("frame%0d_left_early", frames_done),  el, cur);
        chk($sformatf("frame%0d_left_late", frames_done),   ll, cur);
        chk($sformatf("frame%0d_right_early", frames_done), er, cur);
        chk($sformatf("frame%0d_right_late", frames_done),  lr, cur);
        frames_done++;
        have_frame = 1'b0;
      end
    end
  end

  // Stimulus: frame k spans cycles 512k..512k+511 after reset release.
  initial begin
    exp_q.push_back(16'h0000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    now_t = 0;

    for (int k = 0; k < 11; k++) begin
      go_to(512 * k + 10);
      volume = VOL_A[k];
      exp_q.push_back(EXP_A[k]);
    end

    // Silence mid-frame 11: frame 11 keeps its word, frames 12/13 are zero.
    go_to(512 * 11 + 200);
    note_div = 22'd0;
    exp_q.push_back(16'h0000);
    go_to(512 * 12 + 10);
    exp_q.push_back(16'h0000);

    // Tone restart from silence, 1024-cycle half period.
    go_to(512 * 13);
    note_div = 22'd1024;
    exp_q.push_back(16'hF800);
    go_to(512 * 14 + 10);
    exp_q.push_back(16'hF800);
    go_to(512 * 15 + 10);
    exp_q.push_back(16'h0800);
    go_to(512 * 16 + 10);
    exp_q.push_back(16'h0800);

    // Shorter note while hcnt = 400.
    go_to(512 * 17 + 400);
    note_div = 22'd300;
    exp_q.push_back(EXP_B[0]);
    for (int k = 18; k < 22; k++) begin
      go_to(512 * k + 10);
      exp_q.push_back(EXP_B[k - 17]);
    end

    // Reset in the middle of frame 22.
    go_to(512 * 22 + 300);
    note_div = 22'd512;
    volume = 3'd2;
    rst = 1'b1;
    exp_q.push_back(16'h0000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    now_t = 0;
    go_to(10);
    exp_q.push_back(16'hF800);
    go_to(512 + 10);
    exp_q.push_back(16'h0800);
    go_to(512 * 3);

    chk("frames_checked", 16'(frames_done), 16'd25);
    chk("queue_left", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
